control_fsm: RTL and testbench



---
 rtl/control_fsm_if.sv | 35 +++
 rtl/control_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_control_fsm.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Instruction/strobe bundle between the ROM/PC side and the sequenced control FSM.
// master drives the instruction fields; slave (the FSM) drives the datapath strobes.
interface control_fsm_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             TypeBit;
  logic [OP_W-1:0]  OP;
  logic             RegWrite;
  logic             AccWrite;
  logic             Branch;
  logic             ReadMem;
  logic             WriteMem;
  logic             LookUp;
  logic             Of0;
  logic             IsMem;
  logic             PCEn;
  logic             Busy;
  logic             Done;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstCount;

  modport master (
    output Start, TypeBit, OP,
    input  RegWrite, AccWrite, Branch, ReadMem, WriteMem, LookUp, Of0, IsMem,
    input  PCEn, Busy, Done, IllegalOp, InstCount
  );

  modport slave (
    input  Start, TypeBit, OP,
    output RegWrite, AccWrite, Branch, ReadMem, WriteMem, LookUp, Of0, IsMem,
    output PCEn, Busy, Done, IllegalOp, InstCount
  );
endinterface

// File: rtl/control_fsm.sv
// Sequenced accumulator-ISA control: decodes TypeBit/OP into datapath strobes under a
// Start/Halt run state machine with multi-cycle memory waits and a retire counter.
module control_fsm #(
  parameter int OP_W    = 4,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input logic          Clk,
  input logic          Reset,
  control_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam int WCNT_W    = $clog2(MEM_LAT) + 1;
  localparam int WAIT_INIT = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_INIT);
  localparam logic [WCNT_W-1:0] WCNT_ZERO = WCNT_W'(32'd0);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [OP_W-1:0] OP_PUT   = OP_W'(32'd1);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(32'd2);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(32'd3);
  localparam logic [OP_W-1:0] OP_LUT   = OP_W'(32'd8);
  localparam logic [OP_W-1:0] OP_CLRO  = OP_W'(32'd13);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(32'd14);

  state_t            state_r;
  state_t            nextState_s;
  logic [WCNT_W-1:0] wCnt_r;
  logic [WCNT_W-1:0] nextWCnt_s;
  logic [CNT_W-1:0]  instCount_r;
  logic              illegal_r;

  logic retire_s;
  logic setIllegal_s;
  logic clearRun_s;
  logic regWrite_s;
  logic accWrite_s;
  logic branch_s;
  logic readMem_s;
  logic writeMem_s;
  logic lookUp_s;
  logic of0_s;
  logic isMem_s;
  logic pcEn_s;

  // Next-state, wait-counter and strobe decode from state, instruction and wait count.
  always_comb begin
    nextState_s  = state_r;
    nextWCnt_s   = wCnt_r;
    retire_s     = 1'b0;
    setIllegal_s = 1'b0;
    clearRun_s   = 1'b0;
    regWrite_s   = 1'b0;
    accWrite_s   = 1'b0;
    branch_s     = 1'b0;
    readMem_s    = 1'b0;
    writeMem_s   = 1'b0;
    lookUp_s     = 1'b0;
    of0_s        = 1'b0;
    isMem_s      = 1'b0;
    pcEn_s       = 1'b0;

    case (state_r)
      IDLE, HALTED: begin
        if (bus.Start) begin
          nextState_s = RUN;
          clearRun_s  = 1'b1;
        end else begin
          nextState_s = state_r;
        end
      end

      RUN: begin
        if (bus.TypeBit) begin
          branch_s = 1'b1;
          pcEn_s   = 1'b1;
          retire_s = 1'b1;
        end else begin
          case (bus.OP)
            OP_W'(32'd0), OP_W'(32'd4), OP_W'(32'd5), OP_W'(32'd6), OP_W'(32'd7),
            OP_W'(32'd9), OP_W'(32'd10), OP_W'(32'd11), OP_W'(32'd12): begin
              accWrite_s = 1'b1;
              pcEn_s     = 1'b1;
              retire_s   = 1'b1;
            end
            OP_PUT: begin
              regWrite_s = 1'b1;
              pcEn_s     = 1'b1;
              retire_s   = 1'b1;
            end
            OP_LUT: begin
              accWrite_s = 1'b1;
              lookUp_s   = 1'b1;
              pcEn_s     = 1'b1;
              retire_s   = 1'b1;
            end
            OP_CLRO: begin
              of0_s    = 1'b1;
              pcEn_s   = 1'b1;
              retire_s = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              if (MEM_LAT > 1) begin
                // Load opens the read on the first cycle; store holds its write for the last.
                readMem_s   = (bus.OP == OP_LOAD);
                nextWCnt_s  = WCNT_INIT;
                nextState_s = MEMWAIT;
              end else begin
                if (bus.OP == OP_LOAD) begin
                  readMem_s  = 1'b1;
                  isMem_s    = 1'b1;
                  accWrite_s = 1'b1;
                end else begin
                  writeMem_s = 1'b1;
                end
                pcEn_s   = 1'b1;
                retire_s = 1'b1;
              end
            end
            OP_HALT: begin
              retire_s    = 1'b1;
              nextState_s = HALTED;
            end
            default: begin
              pcEn_s       = 1'b1;
              retire_s     = 1'b1;
              setIllegal_s = 1'b1;
            end
          endcase
        end
      end

      MEMWAIT: begin
        readMem_s = (bus.OP == OP_LOAD);
        if (wCnt_r != WCNT_ZERO) begin
          nextWCnt_s = wCnt_r - WCNT_ONE;
        end else begin
          if (bus.OP == OP_LOAD) begin
            isMem_s    = 1'b1;
            accWrite_s = 1'b1;
          end else begin
            writeMem_s = 1'b1;
          end
          pcEn_s      = 1'b1;
          retire_s    = 1'b1;
          nextState_s = RUN;
        end
      end

      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State, wait counter, saturating retire counter and sticky illegal flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      wCnt_r      <= WCNT_ZERO;
      instCount_r <= CNT_ZERO;
      illegal_r   <= 1'b0;
    end else begin
      state_r <= nextState_s;
      wCnt_r  <= nextWCnt_s;
      if (clearRun_s) begin
        instCount_r <= CNT_ZERO;
        illegal_r   <= 1'b0;
      end else begin
        if (retire_s && (instCount_r != CNT_MAX)) begin
          instCount_r <= instCount_r + CNT_ONE;
        end else begin
          instCount_r <= instCount_r;
        end
        if (setIllegal_s) begin
          illegal_r <= 1'b1;
        end else begin
          illegal_r <= illegal_r;
        end
      end
    end
  end

  assign bus.RegWrite  = regWrite_s;
  assign bus.AccWrite  = accWrite_s;
  assign bus.Branch    = branch_s;
  assign bus.ReadMem   = readMem_s;
  assign bus.WriteMem  = writeMem_s;
  assign bus.LookUp    = lookUp_s;
  assign bus.Of0       = of0_s;
  assign bus.IsMem     = isMem_s;
  assign bus.PCEn      = pcEn_s;
  assign bus.Busy      = (state_r == RUN) || (state_r == MEMWAIT);
  assign bus.Done      = (state_r == HALTED);
  assign bus.IllegalOp = illegal_r;
  assign bus.InstCount = instCount_r;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: three instances cover MEM_LAT=3, single-cycle memory
// with a 2-bit saturating counter, and reset abort during a MEM_LAT=4 store.
module tb_control_fsm;

  localparam logic [8:0] S_NONE = 9'h000;
  localparam logic [8:0] S_RW   = 9'h100;
  localparam logic [8:0] S_AW   = 9'h080;
  localparam logic [8:0] S_BR   = 9'h040;
  localparam logic [8:0] S_RM   = 9'h020;
  localparam logic [8:0] S_WM   = 9'h010;
  localparam logic [8:0] S_LU   = 9'h008;
  localparam logic [8:0] S_O0   = 9'h004;
  localparam logic [8:0] S_IM   = 9'h002;
  localparam logic [8:0] S_PC   = 9'h001;

  logic clk = 1'b0;
  logic rstA, rstB, rstC;
  logic monArm = 1'b0;
  logic wmSeen = 1'b0;
  int   errCnt = 0;
  int   chkCnt = 0;

  control_fsm_if #(.OP_W(4), .CNT_W(16)) ifA ();
  control_fsm_if #(.OP_W(4), .CNT_W(2))  ifB ();
  control_fsm_if #(.OP_W(4), .CNT_W(16)) ifC ();

  control_fsm #(.OP_W(4), .MEM_LAT(3), .CNT_W(16)) dutA (.Clk(clk), .Reset(rstA), .bus(ifA));
  control_fsm #(.OP_W(4), .MEM_LAT(1), .CNT_W(2))  dutB (.Clk(clk), .Reset(rstB), .bus(ifB));
  control_fsm #(.OP_W(4), .MEM_LAT(4), .CNT_W(16)) dutC (.Clk(clk), .Reset(rstC), .bus(ifC));

  wire [8:0] strA = {ifA.RegWrite, ifA.AccWrite, ifA.Branch, ifA.ReadMem, ifA.WriteMem,
                     ifA.LookUp, ifA.Of0, ifA.IsMem, ifA.PCEn};
  wire [8:0] strB = {ifB.RegWrite, ifB.AccWrite, ifB.Branch, ifB.ReadMem, ifB.WriteMem,
                     ifB.LookUp, ifB.Of0, ifB.IsMem, ifB.PCEn};
  wire [8:0] strC = {ifC.RegWrite, ifC.AccWrite, ifC.Branch, ifC.ReadMem, ifC.WriteMem,
                     ifC.LookUp, ifC.Of0, ifC.IsMem, ifC.PCEn};

  always #5 clk = ~clk;

  // Latch any store pulse seen on instance C once the reset abort has been issued.
  always @(posedge clk) begin
    if (monArm && ifC.WriteMem) wmSeen <= 1'b1;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    ifA.Start = 1'b0; ifA.TypeBit = 1'b0; ifA.OP = 4'd0;
    ifB.Start = 1'b0; ifB.TypeBit = 1'b0; ifB.OP = 4'd0;
    ifC.Start = 1'b0; ifC.TypeBit = 1'b0; ifC.OP = 4'd0;
    tick();

    // Reset state
    checkVal("rst_strobes", 32'(strA), 32'(S_NONE));
    checkVal("rst_busy", 32'(ifA.Busy), 32'd0);
    checkVal("rst_done", 32'(ifA.Done), 32'd0);
    checkVal("rst_cnt", 32'(ifA.InstCount), 32'd0);
    checkVal("rst_ill", 32'(ifA.IllegalOp), 32'd0);
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    tick();

    // A: start from IDLE, ALU / put / branch / lookup / clear-overflow
    ifA.Start = 1'b1; #1;
    checkVal("idle_strobes", 32'(strA), 32'(S_NONE));
    checkVal("idle_busy", 32'(ifA.Busy), 32'd0);
    tick();
    ifA.Start = 1'b0; ifA.OP = 4'd11; #1;
    checkVal("op11", 32'(strA), 32'(S_AW | S_PC));
    checkVal("run_busy", 32'(ifA.Busy), 32'd1);
    checkVal("run_cnt0", 32'(ifA.InstCount), 32'd0);
    tick();
    ifA.OP = 4'd1; ifA.Start = 1'b1; #1;
    checkVal("op1", 32'(strA), 32'(S_RW | S_PC));
    tick();
    ifA.Start = 1'b0; ifA.TypeBit = 1'b1; ifA.OP = 4'd2; #1;
    checkVal("branch", 32'(strA), 32'(S_BR | S_PC));
    tick();
    ifA.TypeBit = 1'b0; ifA.OP = 4'd8; #1;
    checkVal("cnt3", 32'(ifA.InstCount), 32'd3);
    checkVal("op8", 32'(strA), 32'(S_AW | S_LU | S_PC));
    tick();
    ifA.OP = 4'd13; #1;
    checkVal("op13", 32'(strA), 32'(S_O0 | S_PC));
    tick();

    // A: MEM_LAT=3 load then store
    ifA.OP = 4'd2; #1;
    checkVal("ld_c1", 32'(strA), 32'(S_RM));
    tick();
    checkVal("ld_c2", 32'(strA), 32'(S_RM));
    checkVal("ld_busy", 32'(ifA.Busy), 32'd1);
    tick();
    checkVal("ld_c3", 32'(strA), 32'(S_RM | S_IM | S_AW | S_PC));
    tick();
    ifA.OP = 4'd3; #1;
    checkVal("st_c1", 32'(strA), 32'(S_NONE));
    checkVal("st_cnt", 32'(ifA.InstCount), 32'd6);
    tick();
    checkVal("st_c2", 32'(strA), 32'(S_NONE));
    tick();
    checkVal("st_c3", 32'(strA), 32'(S_WM | S_PC));
    tick();

    // A: illegal opcode, sticky flag, halt
    ifA.OP = 4'd15; #1;
    checkVal("ill_strobes", 32'(strA), 32'(S_PC));
    checkVal("ill_pre", 32'(ifA.IllegalOp), 32'd0);
    tick();
    ifA.OP = 4'd0; #1;
    checkVal("ill_set", 32'(ifA.IllegalOp), 32'd1);
    checkVal("op0", 32'(strA), 32'(S_AW | S_PC));
    tick();
    ifA.OP = 4'd14; #1;
    checkVal("halt_strobes", 32'(strA), 32'(S_NONE));
    checkVal("halt_cnt", 32'(ifA.InstCount), 32'd9);
    checkVal("ill_sticky", 32'(ifA.IllegalOp), 32'd1);
    tick();
    checkVal("done", 32'(ifA.Done), 32'd1);
    checkVal("done_busy", 32'(ifA.Busy), 32'd0);
    checkVal("done_cnt", 32'(ifA.InstCount), 32'd10);
    checkVal("done_strobes", 32'(strA), 32'(S_NONE));
    tick();
    checkVal("done_hold", 32'(ifA.Done), 32'd1);
    checkVal("cnt_frozen", 32'(ifA.InstCount), 32'd10);
    ifA.Start = 1'b1; #1;
    checkVal("done_start", 32'(ifA.Done), 32'd1);
    tick();
    ifA.Start = 1'b0; ifA.OP = 4'd11; #1;
    checkVal("restart_busy", 32'(ifA.Busy), 32'd1);
    checkVal("restart_cnt", 32'(ifA.InstCount), 32'd0);
    checkVal("restart_ill", 32'(ifA.IllegalOp), 32'd0);
    tick();

    // A: asynchronous reset mid-cycle, then restart
    #1;
    checkVal("pre_arst", 32'(strA), 32'(S_AW | S_PC));
    checkVal("pre_arst_cnt", 32'(ifA.InstCount), 32'd1);
    rstA = 1'b1; #1;
    checkVal("arst_strobes", 32'(strA), 32'(S_NONE));
    checkVal("arst_busy", 32'(ifA.Busy), 32'd0);
    checkVal("arst_cnt", 32'(ifA.InstCount), 32'd0);
    tick();
    rstA = 1'b0; ifA.Start = 1'b1;
    tick();
    ifA.Start = 1'b0; #1;
    checkVal("arst_restart", 32'(ifA.Busy), 32'd1);
    checkVal("arst_restart_cnt", 32'(ifA.InstCount), 32'd0);

    // B: single-cycle memory and 2-bit saturating counter
    ifB.Start = 1'b1;
    tick();
    ifB.Start = 1'b0; ifB.OP = 4'd2; #1;
    checkVal("b_ld", 32'(strB), 32'(S_RM | S_IM | S_AW | S_PC));
    tick();
    ifB.OP = 4'd3; #1;
    checkVal("b_st", 32'(strB), 32'(S_WM | S_PC));
    checkVal("b_cnt1", 32'(ifB.InstCount), 32'd1);
    tick();
    ifB.OP = 4'd0; #1;
    checkVal("b_cnt2", 32'(ifB.InstCount), 32'd2);
    tick();
    ifB.OP = 4'd4; #1;
    checkVal("b_cnt3", 32'(ifB.InstCount), 32'd3);
    tick();
    ifB.OP = 4'd5; #1;
    checkVal("b_sat4", 32'(ifB.InstCount), 32'd3);
    tick();
    checkVal("b_sat5", 32'(ifB.InstCount), 32'd3);

    // C: reset in cycle 2 of a MEM_LAT=4 store must suppress the write pulse
    ifC.Start = 1'b1;
    tick();
    ifC.Start = 1'b0; ifC.OP = 4'd3; #1;
    checkVal("c_st_c1", 32'(strC), 32'(S_NONE));
    tick();
    checkVal("c_st_c2", 32'(strC), 32'(S_NONE));
    checkVal("c_busy", 32'(ifC.Busy), 32'd1);
    #1;
    rstC = 1'b1; monArm = 1'b1; #1;
    checkVal("c_arst_strobes", 32'(strC), 32'(S_NONE));
    checkVal("c_arst_busy", 32'(ifC.Busy), 32'd0);
    tick();
    tick();
    rstC = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkVal("c_no_write", 32'(wmSeen), 32'd0);
    checkVal("c_idle", 32'(ifC.Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
